sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (the execute stage's load/store path).
- Request interface is req/addr_ok/data_ok, split address and data phases.
- Performs address-phase arbitration, holding the granted request stable until it is accepted.
- Tracks outstanding transactions in an in-order source-ID queue and routes each response back to its issuer.
- Data requests have priority; a starvation counter bounds how long fetch can be blocked.

Parameters:
OUTSTANDING, 2, max accepted-but-unanswered transactions (ID queue depth, power of 2, >=1)
STARVE_LIMIT, 3, consecutive data grants while inst_req is pending before inst is forced to win

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
inst_req  in  1  fetch request valid; held stable until inst_addr_ok
inst_wr  in  1  write flag (0 for fetch)
inst_size  in  2  0=byte, 1=half, 2=word
inst_wstrb  in  4  byte write strobes
inst_addr  in  32  byte address
inst_wdata  in  32  write data
inst_addr_ok  out  1  address phase accepted this cycle
inst_data_ok  out  1  response for fetch this cycle
inst_rdata  out  32  read data, valid with inst_data_ok
data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data requester; same meanings as inst_*
data_addr_ok, data_data_ok, data_rdata  out  1/1/32  same meanings as inst_*
mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  shared downstream request
mem_addr_ok  in  1  downstream accepted request
mem_data_ok  in  1  downstream response; responses are in request order
mem_rdata  in  32  downstream read data

Behaviour:
- States: IDLE, HOLD. Registers: state, owner (0=inst, 1=data), ID queue with count, starve_cnt.
- can_issue = (count < OUTSTANDING). A pop in the same cycle does not free a slot for that cycle's grant.
- Request-path selection:
  - In IDLE with can_issue, the winner is selected combinationally.
  - Inst wins if inst_req & (~data_req | starve_cnt == STARVE_LIMIT); otherwise data wins if data_req.
  - The winner's fields drive mem_* the same cycle, so grant latency is 0 cycles.
- Handshake outcomes:
  - If mem_addr_ok in the same cycle, the winner's addr_ok = 1, its ID is pushed, and state stays IDLE.
  - If not, state goes to HOLD with owner latched.
  - In HOLD: mem_req = 1 with fields muxed from owner, and the requester's current fields pass through.
  - In HOLD, the non-owner's addr_ok = 0, even if it raises a higher-priority request.
  - On mem_addr_ok in HOLD: owner's addr_ok = 1, push owner, return to IDLE. The next grant can happen the following cycle.
- In IDLE with ~can_issue or no requests: mem_req = 0 and both addr_ok = 0.
- addr_ok is always the combinational AND of the mem_addr_ok pass-through and the grant. It is never asserted without the matching *_req.
- Response path:
  - On mem_data_ok with count > 0: the head ID selects the target; that target's data_ok = 1 and rdata = mem_rdata, then pop.
  - The non-target's data_ok = 0. Both rdata outputs may carry mem_rdata; only data_ok qualifies them.
  - Write transactions also receive one data_ok.
  - mem_data_ok with count == 0 is ignored: no pop, no data_ok.
- Simultaneous push and pop: count unchanged and pointers both advance. Pointers wrap modulo OUTSTANDING.
- starve_cnt:
  - +1 on each data grant (handshake complete) while inst_req = 1, saturating at STARVE_LIMIT.
  - Cleared on an inst grant or whenever inst_req = 0.
- Reset: state = IDLE, count = 0, pointers = 0, starve_cnt = 0, owner = 0. All outputs are 0 in the reset cycle and the cycle after.
- Reset mid-operation discards in-flight IDs. Late mem_data_ok responses after reset hit an empty queue and are dropped.
- Widths pass through unmodified; no address or strobe manipulation happens here.

Decomposition:
- Shared package holds:
  - SRC_INST = 1'b0, SRC_DATA = 1'b1
  - state encoding ARB_IDLE = 1'b0, ARB_HOLD = 1'b1
  - SIZE_BYTE/HALF/WORD = 2'd0/1/2
- One sub-module, arb_id_fifo: a synchronous 1-bit-wide FIFO of depth OUTSTANDING with push, pop, head, count and full outputs. It clears on reset.
- Arbitration, hold FSM and starvation logic stay in the top module.

Test Plan:
1. Only inst_req, addr 0x1c000000, mem_addr_ok = 1 the same cycle → inst_addr_ok = 1 that cycle. mem_data_ok 2 cycles later with rdata 0x02800000 → inst_data_ok = 1, inst_rdata = 0x02800000, data_data_ok = 0.
2. inst_req and data_req together, data st.w addr 0x10 wstrb 0xF, mem_addr_ok = 1 → data granted first (mem_wr = 1, mem_addr = 0x10). Inst is granted next cycle. Responses in order → data_data_ok, then inst_data_ok.
3. mem_addr_ok held 0 for 3 cycles on an inst grant; data_req rises in cycle 2 → mem_addr stays inst_addr and data_addr_ok = 0 throughout. Grant completes on the cycle mem_addr_ok = 1; data is granted next cycle.
4. OUTSTANDING = 2, two accepted with no responses, third request pending → mem_req = 0 until a mem_data_ok pops; third request is granted the following cycle.
5. data_req and inst_req continuously high, STARVE_LIMIT = 3, mem_addr_ok = 1 → grant sequence D, D, D, I, D, D, D, I.
6. Reset asserted with 2 outstanding, then mem_data_ok pulses after reset → no *_data_ok asserted; count = 0; a new inst request completes normally.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM request arbiter: source IDs, FSM encoding,
// transfer-size codes and the bundled request-field struct.
package sram_req_arbiter_pkg;

    // Source ID stored in the outstanding-transaction queue.
    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    // Address-phase arbitration state.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    // Transfer size encoding shared by all three request ports.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // All request-side fields that travel together with a *_req.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_fields_t;

endpackage

// File: rtl/sram_req_arbiter_id_fifo.sv
// In-order queue of 1-bit source IDs for accepted-but-unanswered transactions.
// Pointers wrap modulo DEPTH; push and pop in the same cycle leave count unchanged.
module arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       push_id,
    input  logic                       pop,
    output logic                       head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] ids;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CW'(DEPTH));
    assign push_en = push & ~full;
    assign pop_en  = pop & (count != '0);
    assign head    = ids[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_en)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // ID storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count gates every read, so stale
        // entries are never observed and the array maps to plain registers.
        if (push_en) ids[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between instruction fetch and the data path.
// Data has priority; a starvation counter forces fetch through after
// STARVE_LIMIT consecutive data grants. Responses return in request order and
// are routed to their issuer through an in-order source-ID queue.
module sram_req_arbiter #(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    import sram_req_arbiter_pkg::*;

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    arb_state_e  state_q, state_d;
    src_e        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic        reset_q;
    logic        out_block;

    logic        grant;
    src_e        grant_src;
    logic        grant_req;
    logic        handshake;
    logic        inst_forced;

    logic [CW-1:0] id_count;
    logic        id_full;
    logic        id_empty;
    logic        id_head;
    logic        resp_fire;

    mem_fields_t inst_fields;
    mem_fields_t data_fields;
    mem_fields_t sel_fields;

    // Outputs stay quiet during reset and the cycle after it.
    assign out_block = reset | reset_q;

    assign inst_fields = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                           addr: inst_addr, wdata: inst_wdata};
    assign data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                           addr: data_addr, wdata: data_wdata};

    assign inst_forced = (starve_q == SW'(STARVE_LIMIT));

    // State, owner and starvation registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= SRC_INST;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Delayed copy of reset that blocks the first post-reset cycle.
    always_ff @(posedge clk) begin
        reset_q <= reset;
    end

    // Grant selection and hold FSM next state.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        owner_d   = owner_q;
        grant     = 1'b0;
        grant_src = SRC_INST;
        unique case (state_q)
            ARB_IDLE: begin
                // A pop this cycle does not free a slot for this cycle's grant.
                if (!id_full) begin
                    if (inst_req && (!data_req || inst_forced)) begin
                        grant     = 1'b1;
                        grant_src = SRC_INST;
                    end else if (data_req) begin
                        grant     = 1'b1;
                        grant_src = SRC_DATA;
                    end
                end
            end
            ARB_HOLD: begin
                grant     = 1'b1;
                grant_src = owner_q;
            end
            default: ;
        endcase
        if (out_block) grant = 1'b0;
        if (grant) begin
            if (mem_addr_ok) begin
                state_d = ARB_IDLE;
            end else begin
                state_d = ARB_HOLD;
                owner_d = grant_src;
            end
        end
    end

    assign grant_req  = (grant_src == SRC_DATA) ? data_req : inst_req;
    assign handshake  = grant & mem_addr_ok & grant_req;
    assign sel_fields = (grant_src == SRC_DATA) ? data_fields : inst_fields;

    assign mem_req   = grant;
    assign mem_wr    = grant ? sel_fields.wr    : 1'b0;
    assign mem_size  = grant ? sel_fields.size  : 2'd0;
    assign mem_wstrb = grant ? sel_fields.wstrb : 4'd0;
    assign mem_addr  = grant ? sel_fields.addr  : 32'd0;
    assign mem_wdata = grant ? sel_fields.wdata : 32'd0;

    assign inst_addr_ok = handshake & (grant_src == SRC_INST);
    assign data_addr_ok = handshake & (grant_src == SRC_DATA);

    // Starvation counter: counts data grants that overtake a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (handshake && grant_src == SRC_INST) begin
            starve_d = '0;
        end else if (!inst_req) begin
            starve_d = '0;
        end else if (handshake && grant_src == SRC_DATA && !inst_forced) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Response routing: the queue head names the issuer of the oldest request.
    assign id_empty     = (id_count == '0);
    assign resp_fire    = mem_data_ok & ~id_empty & ~out_block;
    assign inst_data_ok = resp_fire & (id_head == SRC_INST);
    assign data_data_ok = resp_fire & (id_head == SRC_DATA);
    assign inst_rdata   = out_block ? 32'd0 : mem_rdata;
    assign data_rdata   = out_block ? 32'd0 : mem_rdata;

    arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (handshake),
        .push_id (grant_src),
        .pop     (resp_fire),
        .head    (id_head),
        .count   (id_count),
        .full    (id_full)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_sram_req_arbiter;

    localparam int OUTSTANDING  = 2;
    localparam int STARVE_LIMIT = 3;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    sram_req_arbiter #(
        .OUTSTANDING  (OUTSTANDING),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of issuers awaiting a response, pending held
    // grant, count of data grants that overtook a waiting fetch.
    bit m_q[$];
    bit m_hold   = 0;
    bit m_owner  = 0;
    int m_starve = 0;
    bit m_blk    = 0;

    // Results of the most recent step, sampled at the negative edge.
    bit          last_acc, last_src;
    logic        o_mem_req, o_mem_wr, o_iaok, o_daok, o_idok, o_ddok;
    logic [31:0] o_mem_addr, o_irdata, o_drdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict, compare at negedge, then advance the model.
    task automatic step();
        bit blk, ci, ex_req, ex_src, ex_acc, ex_resp, ex_rsrc;
        @(negedge clk);
        blk    = reset || m_blk;
        ci     = (m_q.size() < OUTSTANDING);
        ex_req = 0;
        ex_src = 0;
        if (!blk) begin
            if (m_hold) begin
                ex_req = 1; ex_src = m_owner;
            end else if (ci && inst_req && (!data_req || m_starve == STARVE_LIMIT)) begin
                ex_req = 1; ex_src = 0;
            end else if (ci && data_req) begin
                ex_req = 1; ex_src = 1;
            end
        end
        ex_acc  = ex_req && mem_addr_ok && (ex_src ? data_req : inst_req);
        ex_resp = !blk && mem_data_ok && (m_q.size() > 0);
        ex_rsrc = ex_resp ? m_q[0] : 1'b0;

        o_mem_req = mem_req;  o_mem_wr = mem_wr;  o_mem_addr = mem_addr;
        o_iaok = inst_addr_ok; o_daok = data_addr_ok;
        o_idok = inst_data_ok; o_ddok = data_data_ok;
        o_irdata = inst_rdata; o_drdata = data_rdata;

        check("mem_req", mem_req, ex_req);
        if (ex_req) begin
            check("mem_addr",  mem_addr,  ex_src ? data_addr  : inst_addr);
            check("mem_wr",    mem_wr,    ex_src ? data_wr    : inst_wr);
            check("mem_size",  mem_size,  ex_src ? data_size  : inst_size);
            check("mem_wstrb", mem_wstrb, ex_src ? data_wstrb : inst_wstrb);
            check("mem_wdata", mem_wdata, ex_src ? data_wdata : inst_wdata);
        end
        check("inst_addr_ok", inst_addr_ok, ex_acc && !ex_src);
        check("data_addr_ok", data_addr_ok, ex_acc && ex_src);
        check("inst_data_ok", inst_data_ok, ex_resp && !ex_rsrc);
        check("data_data_ok", data_data_ok, ex_resp && ex_rsrc);
        if (ex_resp && !ex_rsrc) check("inst_rdata", inst_rdata, mem_rdata);
        if (ex_resp && ex_rsrc)  check("data_rdata", data_rdata, mem_rdata);
        if (blk) begin
            check("blk_mem_addr", mem_addr, 0);
            check("blk_mem_wr", mem_wr, 0);
            check("blk_inst_rdata", inst_rdata, 0);
            check("blk_data_rdata", data_rdata, 0);
        end

        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_starve = 0;
            m_hold   = 0;
            m_owner  = 0;
        end else begin
            if (ex_resp) void'(m_q.pop_front());
            if (ex_acc)  m_q.push_back(ex_src);
            if (ex_req) begin
                m_hold  = !mem_addr_ok;
                m_owner = ex_src;
            end
            if (ex_acc && !ex_src)
                m_starve = 0;
            else if (!inst_req)
                m_starve = 0;
            else if (ex_acc && ex_src && m_starve < STARVE_LIMIT)
                m_starve++;
        end
        m_blk    = reset;
        last_acc = ex_acc;
        last_src = ex_src;
        #1;
    endtask

    task automatic set_inst(input bit req, input logic [31:0] addr);
        inst_req = req; inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = addr; inst_wdata = 32'h0;
    endtask

    task automatic set_data(input bit req, input bit wr, input logic [31:0] addr,
                            input logic [3:0] wstrb, input logic [31:0] wdata);
        data_req = req; data_wr = wr; data_size = 2'd2; data_wstrb = wstrb;
        data_addr = addr; data_wdata = wdata;
    endtask

    task automatic set_mem(input bit aok, input bit dok, input logic [31:0] rd);
        mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    endtask

    initial begin
        string pat;
        reset = 1'b1;
        set_inst(0, 32'h0);
        set_data(0, 0, 32'h0, 4'h0, 32'h0);
        set_mem(0, 0, 32'h0);

        // Reset state: outputs quiet during reset and one cycle after.
        step();
        check("rst_mem_req", o_mem_req, 0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_mem_req", o_mem_req, 0);
        check("post_rst_iaok", o_iaok, 0);

        // 1: lone fetch, zero-latency grant, response two cycles later.
        set_inst(1, 32'h1c000000);
        set_mem(1, 0, 32'h0);
        step();
        check("t1_iaok", o_iaok, 1);
        check("t1_mem_addr", o_mem_addr, 32'h1c000000);
        set_inst(0, 32'h0);
        set_mem(0, 0, 32'h0);
        step();
        step();
        set_mem(0, 1, 32'h02800000);
        step();
        check("t1_idok", o_idok, 1);
        check("t1_irdata", o_irdata, 32'h02800000);
        check("t1_ddok", o_ddok, 0);
        set_mem(0, 0, 32'h0);
        step();

        // 2: simultaneous requests, data store wins, fetch follows.
        set_inst(1, 32'h1c000004);
        set_data(1, 1, 32'h10, 4'hf, 32'hcafef00d);
        set_mem(1, 0, 32'h0);
        step();
        check("t2_daok", o_daok, 1);
        check("t2_iaok", o_iaok, 0);
        check("t2_mem_wr", o_mem_wr, 1);
        check("t2_mem_addr", o_mem_addr, 32'h10);
        set_data(0, 0, 32'h0, 4'h0, 32'h0);
        step();
        check("t2_iaok_next", o_iaok, 1);
        check("t2_mem_addr_next", o_mem_addr, 32'h1c000004);
        set_inst(0, 32'h0);
        set_mem(0, 1, 32'h11111111);
        step();
        check("t2_ddok_first", o_ddok, 1);
        check("t2_idok_first", o_idok, 0);
        set_mem(0, 1, 32'h22222222);
        step();
        check("t2_idok_second", o_idok, 1);
        check("t2_irdata_second", o_irdata, 32'h22222222);
        set_mem(0, 0, 32'h0);

        // 3: held fetch grant is not preempted by a later data request.
        set_inst(1, 32'h1c000100);
        step();
        check("t3_hold_c1_addr", o_mem_addr, 32'h1c000100);
        set_data(1, 0, 32'h80000040, 4'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t3_hold_addr", o_mem_addr, 32'h1c000100);
            check("t3_hold_daok", o_daok, 0);
            check("t3_hold_iaok", o_iaok, 0);
        end
        set_mem(1, 0, 32'h0);
        step();
        check("t3_release_iaok", o_iaok, 1);
        check("t3_release_daok", o_daok, 0);
        set_inst(0, 32'h0);
        step();
        check("t3_next_daok", o_daok, 1);
        check("t3_next_addr", o_mem_addr, 32'h80000040);
        set_data(0, 0, 32'h0, 4'h0, 32'h0);
        set_mem(0, 1, 32'h33333333);
        step();
        check("t3_resp1_idok", o_idok, 1);
        step();
        check("t3_resp2_ddok", o_ddok, 1);
        set_mem(0, 0, 32'h0);

        // 4: queue full blocks the third request until a pop has landed.
        set_inst(1, 32'h1c000200);
        set_mem(1, 0, 32'h0);
        step();
        set_inst(0, 32'h0);
        set_data(1, 0, 32'h80000080, 4'h0, 32'h0);
        step();
        set_data(0, 0, 32'h0, 4'h0, 32'h0);
        set_inst(1, 32'h1c000204);
        step();
        check("t4_full_mem_req_a", o_mem_req, 0);
        step();
        check("t4_full_mem_req_b", o_mem_req, 0);
        set_mem(1, 1, 32'h44444444);
        step();
        check("t4_pop_cycle_mem_req", o_mem_req, 0);
        check("t4_pop_idok", o_idok, 1);
        set_mem(1, 0, 32'h0);
        step();
        check("t4_after_pop_mem_req", o_mem_req, 1);
        check("t4_after_pop_iaok", o_iaok, 1);
        set_inst(0, 32'h0);
        set_mem(0, 1, 32'h55555555);
        step();
        check("t4_drain_ddok", o_ddok, 1);
        step();
        check("t4_drain_idok", o_idok, 1);
        set_mem(0, 0, 32'h0);

        // 5: starvation bound under continuous contention.
        set_inst(1, 32'h1c000300);
        set_data(1, 0, 32'h80000100, 4'h0, 32'h0);
        set_mem(1, 0, 32'h0);
        pat = "DDDIDDDI";
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_daok", o_daok, pat[i] == "D");
            check("t5_iaok", o_iaok, pat[i] == "I");
            set_mem(1, 1, 32'h0 + i);
        end
        set_inst(0, 32'h0);
        set_data(0, 0, 32'h0, 4'h0, 32'h0);
        set_mem(0, 1, 32'h66666666);
        step();
        set_mem(0, 0, 32'h0);
        step();

        // 6: reset with two in flight; late responses are dropped.
        set_inst(1, 32'h1c000400);
        set_mem(1, 0, 32'h0);
        step();
        set_inst(0, 32'h0);
        set_data(1, 0, 32'h80000200, 4'h0, 32'h0);
        step();
        set_data(0, 0, 32'h0, 4'h0, 32'h0);
        reset = 1'b1;
        set_inst(1, 32'h1c000500);
        set_mem(1, 1, 32'hdeadbeef);
        step();
        check("t6_rst_mem_req", o_mem_req, 0);
        check("t6_rst_idok", o_idok, 0);
        check("t6_rst_irdata", o_irdata, 0);
        reset = 1'b0;
        step();
        check("t6_after_mem_req", o_mem_req, 0);
        check("t6_after_idok", o_idok, 0);
        check("t6_after_ddok", o_ddok, 0);
        step();
        check("t6_new_iaok", o_iaok, 1);
        check("t6_late_idok", o_idok, 0);
        check("t6_late_ddok", o_ddok, 0);
        set_inst(0, 32'h0);
        set_mem(0, 1, 32'h77777777);
        step();
        check("t6_new_idok", o_idok, 1);
        check("t6_new_irdata", o_irdata, 32'h77777777);
        set_mem(0, 0, 32'h0);
        step();

        // Randomized traffic with requesters that hold until accepted.
        for (int c = 0; c < 600; c++) begin
            if (last_acc && !last_src) inst_req = 1'b0;
            if (last_acc && last_src)  data_req = 1'b0;
            if (!inst_req && $urandom_range(1, 0) == 1)
                set_inst(1, $urandom & 32'hfffffffc);
            if (!data_req && $urandom_range(1, 0) == 1)
                set_data(1, 1'($urandom_range(1, 0)), $urandom,
                         4'($urandom_range(15, 0)), $urandom);
            set_mem($urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0, $urandom);
            reset = ($urandom_range(99, 0) == 0);
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
